// File: rtl/zram_arbiter.sv
// zram_arbiter: shares the single 16x8 RAM port between instruction fetch (F),
// data load/store (D) and the host loader/debug port (H).
//
// A request that wins at a decision edge spends one ACCESS cycle driving the
// RAM. The following RESP cycle returns completion and read data. The edges
// that end IDLE and RESP cycles are the only points where a new winner is
// chosen. Peak throughput is therefore one access every two cycles.
//
// Optional feature macro: ZRAM_ARB_ROUND_ROBIN_EN
//   defined     -> round-robin in ring order F -> D -> H -> F; F goes first after reset
//   not defined -> fixed priority H > D > F (F may starve under heavy H/D load)
//
// Ports
//   CLK, RESET                 clock (rising edge), asynchronous active-high reset
//   x_REQ/x_WE/x_ADDR/x_WDATA  per-requester request, held until x_GNT
//   x_GNT                      one-cycle one-hot grant pulse (ACCESS cycle)
//   x_RVALID, RDATA            one-cycle completion pulse (RESP cycle) + shared read data
//   RAM_ADDR/RAM_OP/RAM_WDATA  RAM drive (RAM_OP 1 = write, high only during ACCESS)
//   RAM_DATA_IN                combinational RAM read data for RAM_ADDR
//   BUSY                       high in ACCESS and RESP
module zram_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              F_REQ,
    input  logic              F_WE,
    input  logic [ADDR_W-1:0] F_ADDR,
    input  logic [DATA_W-1:0] F_WDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    input  logic              H_REQ,
    input  logic              H_WE,
    input  logic [ADDR_W-1:0] H_ADDR,
    input  logic [DATA_W-1:0] H_WDATA,
    output logic              F_GNT,
    output logic              D_GNT,
    output logic              H_GNT,
    output logic              F_RVALID,
    output logic              D_RVALID,
    output logic              H_RVALID,
    output logic [DATA_W-1:0] RDATA,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_OP,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_DATA_IN,
    output logic              BUSY
);

    localparam int unsigned N_REQ = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Requester vectors, bit 0 = F, bit 1 = D, bit 2 = H
    logic [N_REQ-1:0]  w_req;
    logic [N_REQ-1:0]  w_win;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_we;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_take;

    state_t            r_state;
    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  r_rvalid;
    logic [N_REQ-1:0]  r_owner;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_op;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_busy;

    state_t            w_state_nxt;
    logic [N_REQ-1:0]  w_gnt_nxt;
    logic [N_REQ-1:0]  w_rvalid_nxt;
    logic [N_REQ-1:0]  w_owner_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic [ADDR_W-1:0] w_ram_addr_nxt;
    logic              w_ram_op_nxt;
    logic [DATA_W-1:0] w_ram_wdata_nxt;
    logic              w_busy_nxt;

    assign w_req = {H_REQ, D_REQ, F_REQ};

`ifdef ZRAM_ARB_ROUND_ROBIN_EN
    // One-hot record of the last winner; reset to H so F leads the first round
    logic [N_REQ-1:0] r_last;

    // Search starts at the requester after the last winner
    always_comb begin
        w_win = '0;
        case (r_last)
            3'b001: begin
                if (w_req[1])      w_win = 3'b010;
                else if (w_req[2]) w_win = 3'b100;
                else if (w_req[0]) w_win = 3'b001;
            end
            3'b010: begin
                if (w_req[2])      w_win = 3'b100;
                else if (w_req[0]) w_win = 3'b001;
                else if (w_req[1]) w_win = 3'b010;
            end
            default: begin
                if (w_req[0])      w_win = 3'b001;
                else if (w_req[1]) w_win = 3'b010;
                else if (w_req[2]) w_win = 3'b100;
            end
        endcase
    end

    // Pointer moves only when a grant is actually issued
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_last <= 3'b100;
        end else if (w_take && (|w_req)) begin
            r_last <= w_win;
        end
    end
`else
    // Fixed priority H > D > F
    always_comb begin
        w_win = '0;
        if (w_req[2])      w_win = 3'b100;
        else if (w_req[1]) w_win = 3'b010;
        else if (w_req[0]) w_win = 3'b001;
    end
`endif

    // Winner's request fields
    always_comb begin
        w_sel_addr  = F_ADDR;
        w_sel_we    = F_WE;
        w_sel_wdata = F_WDATA;
        if (w_win[1]) begin
            w_sel_addr  = D_ADDR;
            w_sel_we    = D_WE;
            w_sel_wdata = D_WDATA;
        end
        if (w_win[2]) begin
            w_sel_addr  = H_ADDR;
            w_sel_we    = H_WE;
            w_sel_wdata = H_WDATA;
        end
    end

    // State register and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_owner     <= '0;
            r_rdata     <= '0;
            r_ram_addr  <= '0;
            r_ram_op    <= 1'b0;
            r_ram_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rvalid    <= w_rvalid_nxt;
            r_owner     <= w_owner_nxt;
            r_rdata     <= w_rdata_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_op    <= w_ram_op_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = '0;
        w_rvalid_nxt    = '0;
        w_owner_nxt     = r_owner;
        w_rdata_nxt     = r_rdata;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_op_nxt    = 1'b0;
        w_ram_wdata_nxt = r_ram_wdata;
        w_take          = 1'b0;

        case (r_state)
            ST_ACCESS: begin
                // r_ram_op still holds the direction of the access in flight
                w_state_nxt  = ST_RESP;
                w_rvalid_nxt = r_owner;
                if (!r_ram_op) begin
                    w_rdata_nxt = RAM_DATA_IN;
                end
            end
            default: begin
                // IDLE and RESP both end on a decision edge
                w_take = 1'b1;
                if (|w_req) begin
                    w_state_nxt     = ST_ACCESS;
                    w_gnt_nxt       = w_win;
                    w_owner_nxt     = w_win;
                    w_ram_addr_nxt  = w_sel_addr;
                    w_ram_op_nxt    = w_sel_we;
                    w_ram_wdata_nxt = w_sel_wdata;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign F_GNT     = r_gnt[0];
    assign D_GNT     = r_gnt[1];
    assign H_GNT     = r_gnt[2];
    assign F_RVALID  = r_rvalid[0];
    assign D_RVALID  = r_rvalid[1];
    assign H_RVALID  = r_rvalid[2];
    assign RDATA     = r_rdata;
    assign RAM_ADDR  = r_ram_addr;
    assign RAM_OP    = r_ram_op;
    assign RAM_WDATA = r_ram_wdata;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_zram_arbiter.sv
// Testbench for zram_arbiter: directed scenarios followed by random traffic.
// A transaction-level reference model predicts every output on every cycle.
// Build with +define+ZRAM_ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_zram_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [2:0]    tb_req;
    logic [2:0]    tb_we;
    logic [AW-1:0] tb_addr  [3];
    logic [DW-1:0] tb_wdata [3];

    logic          F_GNT, D_GNT, H_GNT, F_RVALID, D_RVALID, H_RVALID;
    logic [DW-1:0] RDATA, RAM_WDATA, ram_din;
    logic [AW-1:0] RAM_ADDR;
    logic          RAM_OP, BUSY;
    logic [2:0]    gnt_obs, rvalid_obs;

    zram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .F_REQ(tb_req[0]), .F_WE(tb_we[0]), .F_ADDR(tb_addr[0]), .F_WDATA(tb_wdata[0]),
        .D_REQ(tb_req[1]), .D_WE(tb_we[1]), .D_ADDR(tb_addr[1]), .D_WDATA(tb_wdata[1]),
        .H_REQ(tb_req[2]), .H_WE(tb_we[2]), .H_ADDR(tb_addr[2]), .H_WDATA(tb_wdata[2]),
        .F_GNT(F_GNT), .D_GNT(D_GNT), .H_GNT(H_GNT),
        .F_RVALID(F_RVALID), .D_RVALID(D_RVALID), .H_RVALID(H_RVALID),
        .RDATA(RDATA), .RAM_ADDR(RAM_ADDR), .RAM_OP(RAM_OP), .RAM_WDATA(RAM_WDATA),
        .RAM_DATA_IN(ram_din), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    assign gnt_obs    = {H_GNT, D_GNT, F_GNT};
    assign rvalid_obs = {H_RVALID, D_RVALID, F_RVALID};

    // RAM: combinational read, write on the edge that ends the write cycle
    logic [DW-1:0] ram [16];
    assign ram_din = ram[RAM_ADDR];
    always @(posedge CLK) if (RAM_OP) ram[RAM_ADDR] = RAM_WDATA;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction is granted at a free edge, occupies one access cycle, then
    // one response cycle; the edge after the response is free again.
    logic [2:0]    e_gnt, e_rvalid;
    logic [DW-1:0] e_rdata, e_wdata;
    logic [AW-1:0] e_addr;
    logic          e_op, e_busy;
    logic [DW-1:0] m_mem [16];
    bit            m_in_access;
    int            m_owner, m_last;
    txn_t          m_txn;

    function automatic int pick(input logic [2:0] r);
`ifdef ZRAM_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (m_last + k) % 3;
            if (r[i]) return i;
        end
`else
        for (int i = 2; i >= 0; i--) if (r[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_wdata = '0;
        e_addr = '0; e_op = 1'b0; e_busy = 1'b0;
        m_in_access = 1'b0; m_owner = 0; m_last = 2;
    endtask

    task automatic model_step();
        int w;
        if (RESET) begin
            model_reset();
            return;
        end
        e_rvalid = '0;
        if (m_in_access) begin
            e_gnt    = '0;
            e_op     = 1'b0;
            e_rvalid = 3'(1 << m_owner);
            if (m_txn.we) m_mem[m_txn.addr] = m_txn.wdata;
            else          e_rdata = m_mem[m_txn.addr];
            e_busy      = 1'b1;
            m_in_access = 1'b0;
        end else begin
            w = pick(tb_req);
            if (w < 0) begin
                e_gnt = '0; e_op = 1'b0; e_busy = 1'b0;
            end else begin
                m_txn       = '{we: tb_we[w], addr: tb_addr[w], wdata: tb_wdata[w]};
                e_gnt       = 3'(1 << w);
                e_addr      = m_txn.addr;
                e_op        = m_txn.we;
                e_wdata     = m_txn.wdata;
                e_busy      = 1'b1;
                m_owner     = w;
                m_last      = w;
                m_in_access = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("gnt",        gnt_obs,    e_gnt);
        check("rvalid",     rvalid_obs, e_rvalid);
        check("rdata",      RDATA,      e_rdata);
        check("ram_addr",   RAM_ADDR,   e_addr);
        check("ram_op",     RAM_OP,     e_op);
        check("ram_wdata",  RAM_WDATA,  e_wdata);
        check("busy",       BUSY,       e_busy);
        check("gnt_onehot", 32'($countones(gnt_obs) <= 1), 1);
    endtask

    // ---------------- requester agents ----------------
    txn_t q_txn [3][$];
    bit   rnd_mode;

    task automatic load(input int r, input txn_t t);
        tb_req[r] = 1'b1; tb_we[r] = t.we; tb_addr[r] = t.addr; tb_wdata[r] = t.wdata;
    endtask

    task automatic agents();
        for (int r = 0; r < 3; r++) begin
            if (rnd_mode && q_txn[r].size() == 0 && $urandom_range(0, 3) == 0)
                q_txn[r].push_back('{we: 1'($urandom_range(0, 1)),
                                     addr: AW'($urandom_range(0, 15)),
                                     wdata: DW'($urandom_range(0, 255))});
            if (tb_req[r] && gnt_obs[r]) begin
                if (q_txn[r].size() > 0) load(r, q_txn[r].pop_front());
                else tb_req[r] = 1'b0;
            end else if (tb_req[r] && rnd_mode && $urandom_range(0, 15) == 0) begin
                tb_req[r] = 1'b0;   // abandoned request
            end else if (!tb_req[r] && q_txn[r].size() > 0) begin
                load(r, q_txn[r].pop_front());
            end
        end
    endtask

    // One cycle: drive at negedge, model at posedge, compare 1 ns later
    task automatic tick();
        @(negedge CLK);
        agents();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_gnt(input int r);
        bit seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick();
            if (gnt_obs[r]) seen = 1'b1;
        end
        check("gnt_seen", 32'(seen), 1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        tick();
        RESET = 1'b0;
    endtask

    logic [2:0] gseq [12];

    initial begin
        RESET    = 1'b1;
        tb_req   = '0;
        tb_we    = '0;
        rnd_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tb_addr[i] = '0; tb_wdata[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            ram[i] = 8'(i * 17 + 1);
        end
        ram[1] = 8'h5A; ram[2] = 8'hC3; ram[3] = 8'hA5;
        for (int i = 0; i < 16; i++) m_mem[i] = ram[i];

        // Reset state
        #1;
        model_reset();
        compare_all();
        tick();
        tick();
        RESET = 1'b0;
        tick();

        // F read of address 3
        q_txn[0].push_back('{we: 1'b0, addr: 4'h3, wdata: 8'h00});
        tick();
        check("f_gnt", F_GNT, 1);
        check("f_ram_addr", RAM_ADDR, 3);
        check("f_ram_op", RAM_OP, 0);
        tick();
        check("f_rvalid", F_RVALID, 1);
        check("f_rdata", RDATA, 8'hA5);
        tick();

        // D write 0x3C to 7, then F read of 7
        q_txn[1].push_back('{we: 1'b1, addr: 4'h7, wdata: 8'h3C});
        tick();
        check("d_gnt", D_GNT, 1);
        check("d_ram_op", RAM_OP, 1);
        check("d_ram_addr", RAM_ADDR, 7);
        check("d_ram_wdata", RAM_WDATA, 8'h3C);
        tick();
        check("d_ram_op_drop", RAM_OP, 0);
        check("d_rvalid", D_RVALID, 1);
        q_txn[0].push_back('{we: 1'b0, addr: 4'h7, wdata: 8'h00});
        wait_gnt(0);
        tick();
        check("f_rvalid_7", F_RVALID, 1);
        check("f_rdata_7", RDATA, 8'h3C);
        tick();

        // Simultaneous requests from a fresh reset
        do_reset();
`ifdef ZRAM_ARB_ROUND_ROBIN_EN
        for (int r = 0; r < 3; r++) begin
            q_txn[r].push_back('{we: 1'b0, addr: AW'(r + 4), wdata: 8'h00});
            q_txn[r].push_back('{we: 1'b0, addr: AW'(r + 8), wdata: 8'h00});
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            gseq[c] = gnt_obs;
        end
        check("rr_g1", gseq[0], 3'b001);
        check("rr_g2", gseq[2], 3'b010);
        check("rr_g3", gseq[4], 3'b100);
        check("rr_g4", gseq[6], 3'b001);
        check("rr_g5", gseq[8], 3'b010);
        check("rr_g6", gseq[10], 3'b100);
`else
        for (int r = 0; r < 3; r++)
            q_txn[r].push_back('{we: 1'b0, addr: AW'(r + 4), wdata: 8'h00});
        for (int c = 0; c < 6; c++) begin
            tick();
            gseq[c] = gnt_obs;
        end
        check("fp_g1", gseq[0], 3'b100);
        check("fp_gap1", gseq[1], 3'b000);
        check("fp_g2", gseq[2], 3'b010);
        check("fp_gap2", gseq[3], 3'b000);
        check("fp_g3", gseq[4], 3'b001);
        check("fp_gap3", gseq[5], 3'b000);
`endif
        tick();
        tick();

        // D holds REQ across two reads
        q_txn[1].push_back('{we: 1'b0, addr: 4'h1, wdata: 8'h00});
        q_txn[1].push_back('{we: 1'b0, addr: 4'h2, wdata: 8'h00});
        tick();
        check("b2b_gnt1", D_GNT, 1);
        check("b2b_busy1", BUSY, 1);
        tick();
        check("b2b_rv1", D_RVALID, 1);
        check("b2b_rd1", RDATA, 8'h5A);
        check("b2b_busy2", BUSY, 1);
        tick();
        check("b2b_gnt2", D_GNT, 1);
        check("b2b_addr2", RAM_ADDR, 2);
        check("b2b_busy3", BUSY, 1);
        tick();
        check("b2b_rv2", D_RVALID, 1);
        check("b2b_rd2", RDATA, 8'hC3);
        check("b2b_busy4", BUSY, 1);
        tick();

        // Reset during the ACCESS cycle of an H write
        q_txn[2].push_back('{we: 1'b1, addr: 4'h9, wdata: 8'h77});
        wait_gnt(2);
        #2;
        RESET = 1'b1;
        #1;
        check("rst_h_gnt", H_GNT, 0);
        check("rst_ram_op", RAM_OP, 0);
        check("rst_busy", BUSY, 0);
        model_reset();
        tick();
        check("rst_no_rvalid", H_RVALID, 0);
        RESET = 1'b0;
        tick();
        check("rearb_h_gnt", H_GNT, 1);
        check("rearb_ram_op", RAM_OP, 1);
        tick();
        check("rearb_h_rvalid", H_RVALID, 1);
        tick();

        // Random traffic
        rnd_mode = 1'b1;
        repeat (3000) tick();
        rnd_mode = 1'b0;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
